// File: rtl/adxl362_pkg.sv
// Shared constants for the ADXL362 register controller: SPI command bytes,
// register map and the transaction FSM state type.
package adxl362_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] DEVID_AD  = 8'h00;
  localparam logic [7:0] DEVID_MST = 8'h01;
  localparam logic [7:0] PARTID    = 8'h02;
  localparam logic [7:0] STATUS    = 8'h0B;
  localparam logic [7:0] POWER_CTL = 8'h2D;

  // POWER_CTL value selecting measurement mode
  localparam logic [7:0] PWR_MEASURE = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StCmd,
    StAddr,
    StData,
    StFinish
  } ctrl_state_e;

endpackage

// File: rtl/adxl362_controller_spi.sv
// Byte-level SPI mode-0 master: shifts one byte MSB first per start pulse and
// optionally keeps CS low afterwards so several bytes share one CS window.
module adxl362_controller_spi #(
  parameter int unsigned CLK_FREQUENCY  = 100_000_000,
  parameter int unsigned SCLK_FREQUENCY = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_to_send,
  input  logic       hold_cs,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_received,
  output logic       sclk,
  output logic       mosi,
  output logic       cs,
  input  logic       miso
);

  localparam int unsigned HalfRaw = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
  localparam int unsigned Half    = (HalfRaw == 0) ? 1 : HalfRaw;
  localparam int unsigned CntW    = (Half > 1) ? $clog2(Half) : 1;

  logic            busy_q, busy_d, done_q, done_d;
  logic            sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
  logic [7:0]      tx_q, tx_d, rx_q, rx_d, rdat_q, rdat_d;
  logic [2:0]      bit_q, bit_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    sclk_d = sclk_q;
    cs_d   = cs_q;
    mosi_d = mosi_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    rdat_d = rdat_q;
    bit_d  = bit_q;
    cnt_d  = cnt_q;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cs_d   = 1'b0;
        tx_d   = data_to_send;
        mosi_d = data_to_send[7];
        bit_d  = 3'd0;
        cnt_d  = '0;
        sclk_d = 1'b0;
      end
    end else if (cnt_q == CntW'(Half - 1)) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
      if (!sclk_q) begin
        rx_d = {rx_q[6:0], miso};
      end else if (bit_q == 3'd7) begin
        // Last falling edge: byte complete, CS released unless the caller holds it
        busy_d = 1'b0;
        done_d = 1'b1;
        rdat_d = rx_q;
        cs_d   = ~hold_cs;
        mosi_d = 1'b0;
      end else begin
        tx_d   = {tx_q[6:0], 1'b0};
        mosi_d = tx_q[6];
        bit_d  = bit_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
      mosi_q <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
      rdat_q <= '0;
      bit_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      sclk_q <= sclk_d;
      cs_q   <= cs_d;
      mosi_q <= mosi_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      rdat_q <= rdat_d;
      bit_q  <= bit_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign data_received = rdat_q;
  assign sclk          = sclk_q;
  assign mosi          = mosi_q;
  assign cs            = cs_q;

endmodule

// File: rtl/adxl362_controller.sv
// ADXL362 register transaction sequencer: command, address and data bytes in one
// CS-low window. Define ADXL362_AUTO_INIT_EN to write measurement mode after reset.
module adxl362_controller
  import adxl362_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY  = 100_000_000,
  parameter int unsigned SCLK_FREQUENCY = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       SPI_SCLK,
  output logic       SPI_MOSI,
  output logic       SPI_CS,
  input  logic       SPI_MISO
);

`ifdef ADXL362_AUTO_INIT_EN
  localparam bit AutoInit = 1'b1;
`else
  localparam bit AutoInit = 1'b0;
`endif

  ctrl_state_e state_q, state_d;
  logic        write_q, write_d, issued_q, issued_d;
  logic        init_pend_q, init_pend_d, init_run_q, init_run_d;
  logic [7:0]  addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  logic       spi_start, spi_busy, spi_done, spi_hold;
  logic [7:0] spi_byte, spi_rx;
  logic       in_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      issued_q    <= 1'b0;
      init_pend_q <= AutoInit;
      init_run_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      issued_q    <= issued_d;
      init_pend_q <= init_pend_d;
      init_run_q  <= init_run_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    issued_d    = issued_q;
    init_pend_d = init_pend_q;
    init_run_d  = init_run_q;
    if (spi_start) issued_d = 1'b1;
    case (state_q)
      StIdle, StFinish: begin
        if (state_q == StIdle && init_pend_q) begin
          state_d = StInit;
        end else if (start) begin
          write_d = write;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = StCmd;
        end else begin
          state_d = StIdle;
        end
      end
      StInit: begin
        write_d     = 1'b1;
        addr_d      = POWER_CTL;
        wdata_d     = PWR_MEASURE;
        init_pend_d = 1'b0;
        init_run_d  = 1'b1;
        state_d     = StCmd;
      end
      StCmd, StAddr, StData: begin
        if (spi_done) begin
          issued_d = 1'b0;
          if (state_q == StCmd) begin
            state_d = StAddr;
          end else if (state_q == StAddr) begin
            state_d = StData;
          end else begin
            rdata_d    = spi_rx;
            init_run_d = 1'b0;
            // The power-up write finishes silently, without a done pulse
            state_d    = init_run_q ? StIdle : StFinish;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    spi_hold  = 1'b0;
    spi_byte  = 8'h00;
    in_phase  = 1'b0;
    case (state_q)
      StInit: busy = 1'b1;
      StCmd: begin
        busy     = 1'b1;
        in_phase = 1'b1;
        spi_hold = 1'b1;
        spi_byte = write_q ? CMD_WRITE : CMD_READ;
      end
      StAddr: begin
        busy     = 1'b1;
        in_phase = 1'b1;
        spi_hold = 1'b1;
        spi_byte = addr_q;
      end
      StData: begin
        busy     = 1'b1;
        in_phase = 1'b1;
        spi_byte = write_q ? wdata_q : 8'h00;
      end
      StFinish: done = 1'b1;
      default: ;
    endcase
    spi_start = in_phase && !issued_q && !spi_busy;
  end

  assign rdata = rdata_q;

  adxl362_controller_spi #(
    .CLK_FREQUENCY (CLK_FREQUENCY),
    .SCLK_FREQUENCY(SCLK_FREQUENCY)
  ) u_spi (
    .clk          (clk),
    .rst          (rst),
    .start        (spi_start),
    .data_to_send (spi_byte),
    .hold_cs      (spi_hold),
    .busy         (spi_busy),
    .done         (spi_done),
    .data_received(spi_rx),
    .sclk         (SPI_SCLK),
    .mosi         (SPI_MOSI),
    .cs           (SPI_CS),
    .miso         (SPI_MISO)
  );

endmodule

// File: tb/tb_adxl362_controller.sv
// Bench for adxl362_controller: ADXL362 pin-level model, vector table, hand-written
// corner sequences and randomized transactions against a register-map reference.
module tb_adxl362_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       write = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done;
  logic       SPI_SCLK, SPI_MOSI, SPI_CS;
  logic       SPI_MISO = 1'b0;

  adxl362_controller #(
    .CLK_FREQUENCY (100_000_000),
    .SCLK_FREQUENCY(10_000_000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .SPI_SCLK(SPI_SCLK),
    .SPI_MOSI(SPI_MOSI),
    .SPI_CS  (SPI_CS),
    .SPI_MISO(SPI_MISO)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (done === 1'b1 && busy === 1'b1) overlap_cnt++;
  end

  // ---------------- ADXL362 pin model ----------------
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] adr;
    logic [7:0] dat;
    int         bits;
  } frame_t;

  frame_t      frames[$];
  logic [7:0]  regs[256];
  logic [23:0] sh = '0;
  int          bits = 0;
  logic [7:0]  txb = '0;

  always @(negedge SPI_CS) begin
    bits = 0;
    sh   = '0;
  end

  always @(posedge SPI_SCLK) begin
    if (SPI_CS === 1'b0) begin
      sh = {sh[22:0], SPI_MOSI};
      bits++;
      if (bits == 16) txb = (sh[15:8] == 8'h0B) ? regs[sh[7:0]] : 8'h00;
    end
  end

  always @(negedge SPI_SCLK) begin
    if (SPI_CS === 1'b0 && bits >= 16 && bits < 24) begin
      int idx;
      idx = 23 - bits;
      SPI_MISO = txb[idx];
    end
  end

  always @(posedge SPI_CS) begin
    if (bits > 0) begin
      if (bits == 24 && sh[23:16] == 8'h0A) regs[sh[15:8]] = sh[7:0];
      frames.push_back('{sh[23:16], sh[15:8], sh[7:0], bits});
    end
    bits     = 0;
    SPI_MISO = 1'b0;
  end

  // ---------------- reference register map ----------------
  logic [7:0] ref_mem[256];

  function automatic logic [7:0] ref_txn(input logic w, input logic [7:0] a,
                                         input logic [7:0] d);
    if (w) begin
      ref_mem[a] = d;
      return 8'h00;
    end
    return ref_mem[a];
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; start is seen at the next posedge.
  task automatic start_txn(input logic w, input logic [7:0] a, input logic [7:0] d);
    start = 1'b1;
    write = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) return;
      @(negedge clk);
    end
    check({name, " done timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string name, input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d);
    frame_t f;
    if (frames.size() == 0) begin
      check({name, " frame present"}, 32'd0, 32'd1);
      return;
    end
    f = frames.pop_front();
    check({name, " bits"}, f.bits, 24);
    check({name, " frame"}, {8'h00, f.cmd, f.adr, f.dat}, {8'h00, c, a, d});
  endtask

  // Full transaction against the reference: frame, rdata, one done pulse.
  task automatic run_txn(input string name, input logic w, input logic [7:0] a,
                         input logic [7:0] d);
    int         dc;
    logic [7:0] exp_rd;
    dc     = done_cnt;
    exp_rd = ref_txn(w, a, d);
    start_txn(w, a, d);
    wait_done(name);
    check({name, " rdata"}, rdata, exp_rd);
    @(negedge clk);
    check({name, " done count"}, done_cnt - dc, 1);
    check_frame(name, w ? 8'h0A : 8'h0B, a, w ? d : 8'h00);
  endtask

  task automatic finish_init(input string name);
`ifdef ADXL362_AUTO_INIT_EN
    int dc;
    dc = done_cnt;
    for (int i = 0; i < 2000 && frames.size() == 0; i++) @(negedge clk);
    for (int i = 0; i < 20 && busy === 1'b1; i++) @(negedge clk);
    check({name, " init busy released"}, busy, 1'b0);
    check({name, " init no done"}, done_cnt - dc, 0);
    check_frame({name, " init"}, 8'h0A, 8'h2D, 8'h02);
    ref_mem[8'h2D] = 8'h02;
`else
    check({name, " idle busy"}, busy, 1'b0);
`endif
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } vec_t;

  vec_t vecs[5];

  initial begin
    for (int i = 0; i < 256; i++) begin
      regs[i]    = 8'h00;
      ref_mem[i] = 8'h00;
    end
    regs[0] = 8'hAD; regs[1] = 8'h1D; regs[2] = 8'hF2;
    ref_mem[0] = 8'hAD; ref_mem[1] = 8'h1D; ref_mem[2] = 8'hF2;

    vecs[0] = '{1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h01, 8'h00};
    vecs[2] = '{1'b0, 8'h02, 8'h00};
    vecs[3] = '{1'b1, 8'h20, 8'h52};
    vecs[4] = '{1'b0, 8'h20, 8'h00};

    // Reset held 8 cycles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset cs", SPI_CS, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset rdata", rdata, 8'h00);
    end
    check("reset sclk/mosi", {SPI_SCLK, SPI_MOSI}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    finish_init("post reset");

    // Vector table
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d);
    end

    // Back-to-back: second start lands in the done cycle
    begin
      int dc;
      @(negedge clk);
      dc = done_cnt;
      start_txn(1'b0, 8'h01, 8'h00);
      wait_done("b2b first");
      check("b2b first rdata", rdata, 8'h1D);
      start_txn(1'b0, 8'h02, 8'h00);
      check("b2b no idle gap", busy, 1'b1);
      wait_done("b2b second");
      check("b2b second rdata", rdata, 8'hF2);
      @(negedge clk);
      check("b2b done count", done_cnt - dc, 2);
      check_frame("b2b f1", 8'h0B, 8'h01, 8'h00);
      check_frame("b2b f2", 8'h0B, 8'h02, 8'h00);
    end

    // Start while busy is ignored
    begin
      int dc;
      @(negedge clk);
      dc = done_cnt;
      start_txn(1'b0, 8'h01, 8'h00);
      repeat (60) @(negedge clk);
      start_txn(1'b1, 8'h21, 8'hFF);
      wait_done("busy start");
      check("busy start rdata", rdata, 8'h1D);
      repeat (300) @(negedge clk);
      check("busy start done count", done_cnt - dc, 1);
      check("busy start idle", busy, 1'b0);
      check_frame("busy start", 8'h0B, 8'h01, 8'h00);
      check("busy start no extra frame", frames.size(), 0);
    end

    // Reset during the address byte
    begin
      int dc;
      frame_t f;
      @(negedge clk);
      dc = done_cnt;
      start_txn(1'b0, 8'h00, 8'h00);
      repeat (120) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst cs", SPI_CS, 1'b1);
      check("midrst busy", busy, 1'b0);
      check("midrst rdata", rdata, 8'h00);
      rst = 1'b0;
      repeat (400) @(negedge clk);
      check("midrst no done", done_cnt - dc, 0);
      if (frames.size() == 0) begin
        check("midrst partial frame", 32'd0, 32'd1);
      end else begin
        f = frames.pop_front();
        check("midrst partial short", (f.bits > 8 && f.bits < 16), 1'b1);
      end
      finish_init("midrst");
      @(negedge clk);
      run_txn("midrst read", 1'b0, 8'h00, 8'h00);
`ifdef ADXL362_AUTO_INIT_EN
      @(negedge clk);
      run_txn("powerctl read", 1'b0, 8'h2D, 8'h00);
`endif
    end

    // Randomized transactions
    for (int i = 0; i < 16; i++) begin
      logic       w;
      logic [7:0] a;
      w = 1'($urandom_range(0, 1));
      if (w) a = 8'h20 + 8'($urandom_range(0, 7));
      else a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2))
                                            : 8'h20 + 8'($urandom_range(0, 7));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_txn($sformatf("rand%0d", i), w, a, 8'($urandom));
    end

    check("done/busy overlap", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
